// File: rtl/key_event_arbiter.sv
// Debounces four active-low board keys and turns accepted level changes
// into a single stream of press/release events with a valid/ready handshake.
//
// Per-key debounce FSM:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_STABLE  | synchronized key matches key_level; nothing to confirm
//   ST_CONFIRM | synchronized key differs; counting ticks until accepted
module key_event_arbiter #(
  parameter int TICK_DIV     = 5000,
  parameter int STABLE_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in_key,
  output logic [3:0] key_level,
  output logic       evt_valid,
  output logic [1:0] evt_key,
  output logic       evt_press,
  input  logic       evt_ready,
  output logic       evt_lost
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  typedef enum logic {ST_STABLE, ST_CONFIRM} state_t;

  logic [3:0]    sync_a, sync_b;
  logic [3:0]    pressed;
  logic [TW-1:0] tick_cnt;
  logic          tick;

  state_t        key_state [4];
  state_t        state_nxt [4];
  logic [CW-1:0] stab_cnt  [4];
  logic [CW-1:0] cnt_nxt   [4];
  logic [3:0]    level_nxt;

  // Pending flags: bit 2k = press of key k, bit 2k+1 = release of key k,
  // so the lowest set bit is also the highest-priority event.
  logic [7:0]    pend;
  logic [7:0]    set_flags;
  logic [7:0]    clr_flags;
  logic [7:0]    avail;
  logic          handshake;
  logic          win_found;
  logic [2:0]    win_idx;

  // Two-flop synchronizer; released (high) keys are the reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 4'hF;
      sync_b <= 4'hF;
    end else begin
      sync_a <= in_key;
      sync_b <= sync_a;
    end
  end

  assign pressed = ~sync_b;

  // Shared debounce tick: free-running 0..TICK_DIV-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // Debounce FSM state registers and accepted levels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        key_state[k] <= ST_STABLE;
        stab_cnt[k]  <= '0;
      end
      key_level <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        key_state[k] <= state_nxt[k];
        stab_cnt[k]  <= cnt_nxt[k];
      end
      key_level <= level_nxt;
    end
  end

  // Debounce next-state: a glitch back to the accepted level aborts the count
  // before any tick in that cycle is considered.
  always_comb begin
    level_nxt = key_level;
    set_flags = '0;
    for (int k = 0; k < 4; k++) begin
      state_nxt[k] = key_state[k];
      cnt_nxt[k]   = stab_cnt[k];
      case (key_state[k])
        ST_STABLE: begin
          if (pressed[k] != key_level[k]) begin
            state_nxt[k] = ST_CONFIRM;
            cnt_nxt[k]   = '0;
          end
        end
        ST_CONFIRM: begin
          if (pressed[k] == key_level[k]) begin
            state_nxt[k] = ST_STABLE;
            cnt_nxt[k]   = '0;
          end else if (tick) begin
            if (stab_cnt[k] == CNT_LAST) begin
              level_nxt[k] = ~key_level[k];
              state_nxt[k] = ST_STABLE;
              cnt_nxt[k]   = '0;
              if (key_level[k]) begin
                set_flags[2*k+1] = 1'b1;
              end else begin
                set_flags[2*k] = 1'b1;
              end
            end else begin
              cnt_nxt[k] = stab_cnt[k] + 1'b1;
            end
          end
        end
        default: begin
          state_nxt[k] = ST_STABLE;
          cnt_nxt[k]   = '0;
        end
      endcase
    end
  end

  assign handshake = evt_valid & evt_ready;

  // Flag retired by an accepted event; excluded from this cycle's arbitration.
  always_comb begin
    clr_flags = '0;
    if (handshake) begin
      clr_flags[{evt_key, ~evt_press}] = 1'b1;
    end
  end

  assign avail = pend & ~clr_flags;

  // Fixed-priority pick of the lowest pending index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < 8; i++) begin
      if (avail[i] && !win_found) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
  end

  // Pending flags, sticky overwrite detection and the registered event slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend      <= '0;
      evt_lost  <= 1'b0;
      evt_valid <= 1'b0;
      evt_key   <= '0;
      evt_press <= 1'b0;
    end else begin
      pend <= avail | set_flags;
      if (|(set_flags & avail)) begin
        evt_lost <= 1'b1;
      end
      if (!evt_valid || handshake) begin
        evt_valid <= win_found;
        if (win_found) begin
          evt_key   <= win_idx[2:1];
          evt_press <= ~win_idx[0];
        end
      end
    end
  end

endmodule
